// File: rtl/matrix_sub_rowstream.sv
// Streaming element-wise matrix subtractor: one A row and one B row in, one
// registered difference row out per handshake, with optional saturation.
module matrix_sub_rowstream #(
  parameter int D_W  = 8,
  parameter int SA_R = 16,
  parameter int SA_C = 16,
  parameter int SAT  = 1,
  localparam int IDX_W = (SA_R > 1) ? $clog2(SA_R) : 1
) (
  input  logic                       I_CLK,
  input  logic                       I_RST_N,
  input  logic                       I_START,
  input  logic                       I_VLD,
  output logic                       O_RDY,
  input  logic [SA_C-1:0][D_W-1:0]   I_ROW_1,
  input  logic [SA_C-1:0][D_W-1:0]   I_ROW_2,
  output logic                       O_VLD,
  input  logic                       I_RDY,
  output logic [SA_C-1:0][D_W-1:0]   O_ROW,
  output logic [IDX_W-1:0]           O_ROW_IDX,
  output logic                       O_LAST,
  output logic                       O_DONE,
  output logic                       O_BUSY,
  output logic [1:0]                 O_STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SA_R - 1);

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           cnt_q, cnt_d;
  logic                       vld_q, vld_d;
  logic [SA_C-1:0][D_W-1:0]   row_q, row_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       last_q, last_d;
  logic                       done_q, done_d;
  logic                       rdy;
  logic                       accept;
  logic                       hs;

  function automatic logic [D_W-1:0] sub_elem(input logic [D_W-1:0] a,
                                               input logic [D_W-1:0] b);
    logic signed [D_W:0] diff;
    diff = $signed({a[D_W-1], a}) - $signed({b[D_W-1], b});
    if ((SAT != 0) && (diff[D_W] != diff[D_W-1]))
      sub_elem = diff[D_W] ? {1'b1, {(D_W-1){1'b0}}} : {1'b0, {(D_W-1){1'b1}}};
    else
      sub_elem = diff[D_W-1:0];
  endfunction

  // Valid/ready: a transfer happens on a port when its valid and ready are both
  // high at the rising edge; valid never waits on ready, and the output payload
  // holds while O_VLD is high and I_RDY is low. The input side is ready whenever
  // the output register is empty or being drained in the same cycle.
  always_comb begin
    rdy    = (state_q == S_RUN) && (!vld_q || I_RDY);
    accept = I_VLD && rdy;
    hs     = vld_q && I_RDY;

    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    row_d   = row_q;
    idx_d   = idx_q;
    last_d  = last_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (cnt_q == LAST_IDX) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // DONE cycle still counts as DRAIN so a START landing on it is dropped.
        if (done_q)  state_d = S_IDLE;
        else if (hs) done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      for (int j = 0; j < SA_C; j++) row_d[j] = sub_elem(I_ROW_1[j], I_ROW_2[j]);
      vld_d  = 1'b1;
      idx_d  = cnt_q;
      last_d = (cnt_q == LAST_IDX);
    end else if (hs) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      row_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign O_RDY     = rdy;
  assign O_VLD     = vld_q;
  assign O_ROW     = row_q;
  assign O_ROW_IDX = idx_q;
  assign O_LAST    = last_q;
  assign O_DONE    = done_q;
  assign O_BUSY    = (state_q != S_IDLE);
  assign O_STATE   = state_q;

endmodule

// File: tb/tb_matrix_sub_rowstream.sv
// Bench for matrix_sub_rowstream: a 16x16 saturating instance checked against a
// scoreboard, plus small wrap-mode and single-row instances checked inline.
module tb_matrix_sub_rowstream;

  localparam int R    = 16;
  localparam int C    = 16;
  localparam int SB_W = 1 + 4 + C * 8;

  logic clk, rst_n;

  // main instance: SAT=1, 16x16
  logic start, vld, irdy;
  logic [C-1:0][7:0] row1, row2, o_row;
  logic o_rdy, o_vld, o_last, o_done, o_busy;
  logic [3:0] o_idx;
  logic [1:0] o_state;

  // wrap instance: SAT=0, 2 rows of 4
  logic w_start, w_vld, w_irdy;
  logic [3:0][7:0] w_row1, w_row2, w_o_row;
  logic w_o_rdy, w_o_vld, w_o_last, w_o_done, w_o_busy;
  logic [0:0] w_o_idx;
  logic [1:0] w_o_state;

  // single-row instance: SAT=1, 1 row of 4
  logic s_start, s_vld, s_irdy;
  logic [3:0][7:0] s_row1, s_row2, s_o_row;
  logic s_o_rdy, s_o_vld, s_o_last, s_o_done, s_o_busy;
  logic [0:0] s_o_idx;
  logic [1:0] s_o_state;

  int n_cmp, n_fail, done_cnt, exp_idx;
  bit sb_en, pend_done;
  logic [SB_W-1:0] exp_q[$];

  matrix_sub_rowstream #(.D_W(8), .SA_R(R), .SA_C(C), .SAT(1)) dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_START(start), .I_VLD(vld), .O_RDY(o_rdy),
    .I_ROW_1(row1), .I_ROW_2(row2), .O_VLD(o_vld), .I_RDY(irdy), .O_ROW(o_row),
    .O_ROW_IDX(o_idx), .O_LAST(o_last), .O_DONE(o_done), .O_BUSY(o_busy),
    .O_STATE(o_state));

  matrix_sub_rowstream #(.D_W(8), .SA_R(2), .SA_C(4), .SAT(0)) dut_w (
    .I_CLK(clk), .I_RST_N(rst_n), .I_START(w_start), .I_VLD(w_vld), .O_RDY(w_o_rdy),
    .I_ROW_1(w_row1), .I_ROW_2(w_row2), .O_VLD(w_o_vld), .I_RDY(w_irdy), .O_ROW(w_o_row),
    .O_ROW_IDX(w_o_idx), .O_LAST(w_o_last), .O_DONE(w_o_done), .O_BUSY(w_o_busy),
    .O_STATE(w_o_state));

  matrix_sub_rowstream #(.D_W(8), .SA_R(1), .SA_C(4), .SAT(1)) dut_s (
    .I_CLK(clk), .I_RST_N(rst_n), .I_START(s_start), .I_VLD(s_vld), .O_RDY(s_o_rdy),
    .I_ROW_1(s_row1), .I_ROW_2(s_row2), .O_VLD(s_o_vld), .I_RDY(s_irdy), .O_ROW(s_o_row),
    .O_ROW_IDX(s_o_idx), .O_LAST(s_o_last), .O_DONE(s_o_done), .O_BUSY(s_o_busy),
    .O_STATE(s_o_state));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] model_sub(input logic [7:0] a, input logic [7:0] b);
    int d;
    d = int'($signed(a)) - int'($signed(b));
    if (d > 127) d = 127;
    else if (d < -128) d = -128;
    return d[7:0];
  endfunction

  function automatic logic [SB_W-1:0] make_exp(input logic [C-1:0][7:0] a,
                                               input logic [C-1:0][7:0] b, input int idx);
    logic [C-1:0][7:0] r;
    for (int j = 0; j < C; j++) r[j] = model_sub(a[j], b[j]);
    return {(idx == R - 1), 4'(idx), r};
  endfunction

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 7))
      0: return 8'h7F;
      1: return 8'h80;
      2: return 8'h01;
      3: return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic fill_main(input int mode, input int r);
    for (int j = 0; j < C; j++) begin
      case (mode == 1 ? (j + r) % 4 : 3)
        0: begin row1[j] = 8'h7F; row2[j] = 8'h80; end
        1: begin row1[j] = 8'h80; row2[j] = 8'h01; end
        2: begin row1[j] = 8'hFB; row2[j] = 8'hFB; end
        default: begin row1[j] = pick(); row2[j] = pick(); end
      endcase
    end
  endtask

  // scoreboard monitor on the main instance
  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      if (pend_done) begin
        n_cmp++;
        if (o_done !== 1'b1) begin
          n_fail++;
          $display("FAIL done_pulse: got %b want 1", o_done);
        end
        pend_done = 1'b0;
      end else if (o_done !== 1'b0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL done_spurious: got %b want 0", o_done);
      end
      if (o_done === 1'b1) done_cnt++;
      if (o_vld === 1'b1 && irdy === 1'b1) begin
        logic [SB_W-1:0] want, got;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: got row idx %0d want no output", o_idx);
        end else begin
          want = exp_q.pop_front();
          got  = {o_last, o_idx, o_row};
          if (got !== want) begin
            n_fail++;
            $display("FAIL sb_row: got %h want %h", got, want);
          end
          if (want[SB_W-1]) pend_done = 1'b1;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic drive_rows(input int n, input int p_vld, input int p_rdy,
                            input int start_at, input int mode);
    int sent, base, cyc;
    sent = 0; cyc = 0; base = done_cnt;
    while (done_cnt == base && cyc < 2000) begin
      @(posedge clk); #1;
      start = (start_at >= 0) && (sent == start_at);
      irdy  = ($urandom_range(0, 99) < p_rdy);
      vld   = (sent < n) && ($urandom_range(0, 99) < p_vld);
      fill_main(mode, exp_idx);
      @(negedge clk);
      if (vld && o_rdy) begin
        exp_q.push_back(make_exp(row1, row2, exp_idx));
        exp_idx++;
        sent++;
      end
      cyc++;
    end
    start = 1'b0; vld = 1'b0; irdy = 1'b1;
    n_cmp++;
    if (done_cnt != base + 1) begin
      n_fail++;
      $display("FAIL job_done: got %0d done pulses want 1", done_cnt - base);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d rows left want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1)); vld = 1'($urandom_range(0, 1));
      irdy = 1'($urandom_range(0, 1)); fill_main(0, 0);
      @(negedge clk);
      n_cmp++;
      if ({o_vld, o_rdy, o_last, o_done, o_busy, o_idx, o_row} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got vld%b rdy%b last%b done%b busy%b idx%0d row%h want all 0",
                 o_vld, o_rdy, o_last, o_done, o_busy, o_idx, o_row);
      end
    end
    @(posedge clk); #1 rst_n = 1'b1; start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1 vld = 1'b1; irdy = 1'b1; fill_main(0, 0);
      @(negedge clk);
      n_cmp++;
      if (o_rdy !== 1'b0 || o_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_accept: got rdy %b vld %b want 0 0", o_rdy, o_vld);
      end
    end
    vld = 1'b0;
  endtask

  task automatic test_basic();
    int base, vld_cycles, segs;
    logic prev;
    base = done_cnt; vld_cycles = 0; segs = 0; prev = 1'b0; exp_idx = 0;
    irdy = 1'b1;
    pulse_start();
    for (int k = 0; k < 22; k++) begin
      @(posedge clk); #1;
      vld = (k < 16);
      for (int j = 0; j < C; j++) begin row1[j] = 8'(j + 10); row2[j] = 8'(j); end
      @(negedge clk);
      if (k < 16) begin
        n_cmp++;
        if (o_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL basic_rdy: got %b want 1 (row %0d)", o_rdy, k);
        end
      end
      if (vld && o_rdy) begin
        exp_q.push_back(make_exp(row1, row2, exp_idx));
        exp_idx++;
      end
      if (o_vld) begin
        vld_cycles++;
        n_cmp++;
        if (o_row[C-1] !== 8'd10 || o_row[0] !== 8'd10) begin
          n_fail++;
          $display("FAIL basic_elem: got %0d/%0d want 10", o_row[C-1], o_row[0]);
        end
      end
      if (o_vld && !prev) segs++;
      prev = o_vld;
    end
    vld = 1'b0;
    n_cmp++;
    if (vld_cycles != 16 || segs != 1) begin
      n_fail++;
      $display("FAIL basic_burst: got %0d vld cycles in %0d runs want 16 in 1", vld_cycles, segs);
    end
    n_cmp++;
    if (done_cnt != base + 1) begin
      n_fail++;
      $display("FAIL basic_done: got %0d want 1", done_cnt - base);
    end
  endtask

  task automatic test_saturation();
    logic [3:0][7:0] a0, b0, e0, a1, b1, e1;
    logic [33:0] want;
    int sent, outs, dn;
    exp_idx = 0;
    pulse_start();
    drive_rows(16, 100, 100, -1, 1);
    a0 = {8'hFB, 8'h7F, 8'h7F, 8'h7F}; b0 = {8'hFB, 8'h80, 8'h80, 8'h80};
    e0 = {8'h00, 8'hFF, 8'hFF, 8'hFF};
    a1 = {8'h00, 8'h80, 8'h80, 8'h80}; b1 = {8'h01, 8'h01, 8'h01, 8'h01};
    e1 = {8'hFF, 8'h7F, 8'h7F, 8'h7F};
    sent = 0; outs = 0; dn = 0; w_irdy = 1'b1;
    @(posedge clk); #1 w_start = 1'b1;
    @(posedge clk); #1 w_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      w_vld  = (sent < 2);
      w_row1 = (sent == 0) ? a0 : a1;
      w_row2 = (sent == 0) ? b0 : b1;
      @(negedge clk);
      if (w_vld && w_o_rdy) sent++;
      if (w_o_vld) begin
        want = {(outs == 1), 1'(outs), (outs == 0) ? e0 : e1};
        n_cmp++;
        if ({w_o_last, w_o_idx, w_o_row} !== want) begin
          n_fail++;
          $display("FAIL wrap_row: got %h want %h", {w_o_last, w_o_idx, w_o_row}, want);
        end
        outs++;
      end
      if (w_o_done) dn++;
    end
    w_vld = 1'b0;
    n_cmp++;
    if (outs != 2 || dn != 1) begin
      n_fail++;
      $display("FAIL wrap_job: got %0d rows %0d done want 2 rows 1 done", outs, dn);
    end
  endtask

  task automatic test_backpressure();
    logic [C-1:0][7:0] snap_row;
    logic [3:0] snap_idx;
    exp_idx = 0;
    pulse_start();
    @(posedge clk); #1 vld = 1'b1; irdy = 1'b0; fill_main(0, 0);
    @(negedge clk);
    n_cmp++;
    if (o_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first_rdy: got %b want 1", o_rdy);
    end
    if (vld && o_rdy) begin
      exp_q.push_back(make_exp(row1, row2, exp_idx));
      exp_idx++;
    end
    @(posedge clk); #1 fill_main(0, 0);
    @(negedge clk);
    snap_row = o_row; snap_idx = o_idx;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 vld = 1'b1; irdy = 1'b0; fill_main(0, 0);
      @(negedge clk);
      n_cmp++;
      if (o_vld !== 1'b1 || o_row !== snap_row || o_idx !== snap_idx || o_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: got vld%b idx%0d rdy%b want vld1 idx%0d rdy0 row stable",
                 o_vld, o_idx, o_rdy, snap_idx);
      end
    end
    drive_rows(15, 70, 60, -1, 0);
  endtask

  task automatic test_back_to_back();
    for (int job = 0; job < 4; job++) begin
      exp_idx = 0;
      pulse_start();
      drive_rows(16, 40 + 15 * job, 35 + 15 * job, -1, 0);
    end
  endtask

  task automatic test_reset_midjob();
    int sent, dn;
    sb_en = 1'b0; exp_q.delete(); pend_done = 1'b0;
    sent = 0; dn = 0; irdy = 1'b1;
    pulse_start();
    for (int k = 0; k < 20 && sent < 8; k++) begin
      @(posedge clk); #1 vld = 1'b1; fill_main(0, 0);
      @(negedge clk);
      if (o_rdy) sent++;
    end
    @(posedge clk); #1 vld = 1'b0;
    n_cmp++;
    if (o_vld !== 1'b1 || o_idx !== 4'd7) begin
      n_fail++;
      $display("FAIL mid_row7: got vld%b idx%0d want vld1 idx7", o_vld, o_idx);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_vld, o_rdy, o_last, o_done, o_busy, o_idx, o_row} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: got vld%b rdy%b last%b done%b busy%b idx%0d want all 0",
               o_vld, o_rdy, o_last, o_done, o_busy, o_idx);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_done) dn++;
    end
    n_cmp++;
    if (dn != 0) begin
      n_fail++;
      $display("FAIL mid_no_done: got %0d done pulses want 0", dn);
    end
    exp_idx = 0; sb_en = 1'b1;
    pulse_start();
    drive_rows(16, 80, 80, -1, 0);
  endtask

  task automatic test_protocol();
    logic [3:0][7:0] exp_s;
    int sent, outs, dn;
    exp_idx = 0;
    pulse_start();
    drive_rows(16, 90, 90, 5, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 vld = 1'b1; fill_main(0, 0);
      @(negedge clk);
      n_cmp++;
      if (o_rdy !== 1'b0 || o_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL post_job_idle: got rdy %b busy %b want 0 0", o_rdy, o_busy);
      end
    end
    vld = 1'b0;
    s_row1 = {8'h10, 8'hFB, 8'h80, 8'h7F};
    s_row2 = {8'h03, 8'hFB, 8'h01, 8'h80};
    exp_s  = {8'h0D, 8'h00, 8'h80, 8'h7F};
    sent = 0; outs = 0; dn = 0; s_irdy = 1'b1;
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1 s_start = 1'b0; s_vld = (sent < 1);
      @(negedge clk);
      if (s_vld && s_o_rdy) sent++;
      if (s_o_vld) begin
        outs++;
        n_cmp++;
        if (s_o_row !== exp_s || s_o_idx !== 1'b0 || s_o_last !== 1'b1) begin
          n_fail++;
          $display("FAIL single_row: got %h idx%0d last%b want %h idx0 last1",
                   s_o_row, s_o_idx, s_o_last, exp_s);
        end
      end
      if (s_o_done) begin
        dn++;
        s_start = 1'b1;
      end
    end
    s_start = 1'b0;
    n_cmp++;
    if (outs != 1 || dn != 1) begin
      n_fail++;
      $display("FAIL single_job: got %0d rows %0d done want 1 1", outs, dn);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 s_vld = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (s_o_busy !== 1'b0 || s_o_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL start_on_done: got busy %b rdy %b want 0 0", s_o_busy, s_o_rdy);
      end
    end
    s_vld = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; done_cnt = 0; exp_idx = 0;
    sb_en = 1'b0; pend_done = 1'b0;
    rst_n = 1'b0; start = 1'b0; vld = 1'b0; irdy = 1'b1;
    row1 = '0; row2 = '0;
    w_start = 1'b0; w_vld = 1'b0; w_irdy = 1'b1; w_row1 = '0; w_row2 = '0;
    s_start = 1'b0; s_vld = 1'b0; s_irdy = 1'b1; s_row1 = '0; s_row2 = '0;
    test_reset();
    sb_en = 1'b1;
    test_basic();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_midjob();
    test_protocol();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
